// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and access owner.
package dm_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_PIPE, OWN_EXT} owner_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W   = 3,
  parameter int SAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            cnt <= '0;
    else if (clr)                        cnt <= '0;
    else if (inc && (cnt != W'(SAT)))    cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-ported data memory between the MEM stage and an external
// requester; pipe has priority unless the external side has waited too long.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 2,
  parameter int EXT_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_re,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int WAIT_W = (EXT_MAX_WAIT > 0) ? $clog2(EXT_MAX_WAIT + 1) : 1;

  if (MEM_LAT < 1) begin : g_lat_chk
    $error("dm_arbiter: MEM_LAT must be >= 1");
  end

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dm_req_t;

  state_t            state, state_nxt;
  owner_t            owner;
  dm_req_t           lat;
  logic [CNT_W-1:0]  cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pipe_req, ext_force, ext_win, pipe_win;

  assign pipe_req  = pipe_re | pipe_we;
  assign ext_force = (wait_cnt == WAIT_W'(EXT_MAX_WAIT));

  always_comb begin
    state_nxt = state;
    ext_win   = 1'b0;
    pipe_win  = 1'b0;
    case (state)
      IDLE: begin
        if (ext_req && (!pipe_req || ext_force)) ext_win  = 1'b1;
        else if (pipe_req)                       pipe_win = 1'b1;
        if (ext_win || pipe_win) state_nxt = ACCESS;
      end
      ACCESS:  if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode from the FSM so an async reset kills them immediately.
  assign ext_gnt    = ext_win;
  assign dm_re      = (state == ACCESS) && !lat.we;
  assign dm_we      = (state == ACCESS) && lat.we && (cnt == '0);
  assign dm_addr    = lat.addr;
  assign dm_wdata   = lat.wdata;
  assign ext_rvalid = (state == RESP) && (owner == OWN_EXT) && !lat.we;
  assign stall      = rst && pipe_req && !((state == RESP) && (owner == OWN_PIPE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_PIPE;
      lat        <= '0;
      cnt        <= '0;
      pipe_rdata <= '0;
      ext_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (ext_win) begin
        owner <= OWN_EXT;
        lat   <= '{we: ext_we, addr: ext_addr, wdata: ext_wdata};
        cnt   <= CNT_W'(MEM_LAT - 1);
      end else if (pipe_win) begin
        // Simultaneous re/we is treated as a write.
        owner <= OWN_PIPE;
        lat   <= '{we: pipe_we, addr: pipe_addr, wdata: pipe_wdata};
        cnt   <= CNT_W'(MEM_LAT - 1);
      end else if (state == ACCESS) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (!lat.we) begin
          if (owner == OWN_PIPE) pipe_rdata <= dm_rdata;
          else                   ext_rdata  <= dm_rdata;
        end
      end
    end
  end

  sat_counter #(.W(WAIT_W), .SAT(EXT_MAX_WAIT)) u_wait (
    .clk (clk),
    .rst (rst),
    .inc (ext_req && !ext_gnt),
    .clr (ext_gnt || !ext_req),
    .cnt (wait_cnt)
  );
endmodule
